bf16_fma_result_collector: RTL and testbench
============================================

Name: bf16_fma_result_collector

Overview:
- Receives the FMA pipeline output (16-bit bf16 result plus invalid/overflow/underflow/inexact flags) and buffers it in a small FIFO for a downstream consumer that applies valid/ready backpressure.
- Keeps sticky accumulated exception flags (fflags-style), which software reads and clears.
- Sits between bf16_fma and the accelerator writeback/register-file port.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- WIDTH, 16, result data width (bf16).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  FMA presents a result this cycle.
- in_ready  output  1  collector can accept; equals !full.
- in_result  input  WIDTH  bf16 result from FMA.
- in_invalid  input  1  NV flag of this result.
- in_overflow  input  1  OF flag of this result.
- in_underflow  input  1  UF flag of this result.
- in_inexact  input  1  NX flag of this result.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  consumer takes head entry.
- out_data  output  WIDTH  head entry result.
- out_flags  output  4  head entry flags {NV,OF,UF,NX}.
- fflags  output  4  sticky accumulated flags {NV,OF,UF,NX}.
- fflags_clear  input  1  clear sticky flags.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, active-high): read and write pointers reset to 0, count=0, fflags=0. Resulting outputs: out_valid=0, in_ready=1, out_data=0, out_flags=0. Storage contents are don't-care and are never exposed while empty.
- Push: occurs when in_valid && in_ready. Writes {flags, result} at the write pointer; write pointer increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready. Read pointer increments modulo DEPTH.
- out_data/out_flags: driven combinationally from the entry at the read pointer. Driven to 0 when empty.
- Latency: an entry pushed at edge N is visible on out_valid/out_data after edge N. There is no same-cycle bypass, even when empty.
- Count: updates as +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Full (count==DEPTH): in_ready=0 and in_valid is ignored. No overwrite.
  - A pop on a full cycle does not enable a push in the same cycle; in_ready rises the next cycle.
- Empty (count==0): out_valid=0 and out_ready is ignored. Pointers and count do not underflow.
- Simultaneous push+pop (neither full nor empty): both occur and count is unchanged.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from count, not pointer compare.
- In-flight data: in_result/flags are sampled only on an accepted push. The FMA must hold them while in_valid && !in_ready; the collector does not check this.
- Sticky flags, per edge: fflags_next = (fflags_clear ? 0 : fflags) | (push ? {in_invalid,in_overflow,in_underflow,in_inexact} : 0).
  - Clear and push in the same cycle: the new entry's flags survive.
  - Flags accumulate at push time, not pop time.
- Flags are carried through unmodified. The collector does not canonicalize NaNs or alter the result.
- Reset mid-operation: all buffered entries are discarded immediately (asynchronously) and fflags clears.

Test Plan:
- Reset then single push 0x40E0, flags 0000, out_ready=0 → next cycle out_valid=1, out_data=0x40E0, out_flags=0000, count=1, fflags=0000. Then out_ready=1 for one cycle → out_valid=0, count=0.
- Fill: push 0x3F80, 0x4000, 0x4040, 0x4080 back-to-back with out_ready=0 → count=4, in_ready=0. A fifth push of 0x40A0 is ignored. Drain in order 0x3F80, 0x4000, 0x4040, 0x4080; count returns to 0.
- Wrap and concurrency: continuous in_valid=1 and out_ready=1 for 10 cycles with incrementing data 0x4100+i → count stays at 1 after the first cycle. Outputs appear in order with no loss or duplication across pointer wrap.
- Sticky flags: push 0x7F80 with OF=1,NX=1 then 0x0000 with UF=1,NX=1 → fflags=0111, per-entry out_flags 0101 then 0011. Push 0x7FC0 with NV=1 and fflags_clear=1 in the same cycle → fflags=1000.
- Empty pop / full push guard: out_ready=1 while empty for 3 cycles → count stays 0 and out_data=0. With full, pulse out_ready for one cycle with in_valid=1 → exactly one pop, no push that cycle, in_ready=1 the next cycle.
- Async reset mid-stream: with count=3 and fflags=0101, assert reset between clock edges → out_valid=0, count=0, fflags=0000, in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bf16_fma_result_collector.sv
// Result FIFO between the bf16 FMA and the writeback port.
// Also accumulates sticky {NV,OF,UF,NX} exception flags.
module bf16_fma_result_collector #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_invalid,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  input  logic                     in_inexact,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [3:0]               out_flags,
  output logic [3:0]               fflags,
  input  logic                     fflags_clear,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 4;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_fflags;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_in_flags;
  logic [EW-1:0] w_head;

  // Full/empty come from the occupancy counter, so pointers may wrap freely.
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == {CW{1'b0}});
  assign w_push     = in_valid && !w_full;
  assign w_pop      = out_ready && !w_empty;
  assign w_in_flags = {in_invalid, in_overflow, in_underflow, in_inexact};
  assign w_head     = r_mem[r_rd_ptr];

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? {WIDTH{1'b0}} : w_head[WIDTH-1:0];
  assign out_flags = w_empty ? 4'b0000 : w_head[EW-1:WIDTH];
  assign fflags    = r_fflags;
  assign count     = r_count;

  // Entry storage; contents are never visible while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_in_flags, in_result};
    end
  end

  // Pointers, occupancy and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_fflags <= 4'b0000;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A flag raised by this cycle's push survives a same-cycle clear.
      r_fflags <= (fflags_clear ? 4'b0000 : r_fflags) | (w_push ? w_in_flags : 4'b0000);
    end
  end

endmodule

// File: tb/tb_bf16_fma_result_collector.sv
// Directed table-driven bench for bf16_fma_result_collector (DEPTH=4).
module tb_bf16_fma_result_collector;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_invalid;
  logic        in_overflow;
  logic        in_underflow;
  logic        in_inexact;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_flags;
  logic [3:0]  fflags;
  logic        fflags_clear;
  logic [2:0]  count;

  int n_vec;
  int n_err;

  bf16_fma_result_collector #(.DEPTH(4), .WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_invalid   (in_invalid),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_inexact   (in_inexact),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .fflags       (fflags),
    .fflags_clear (fflags_clear),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] din;
    logic [3:0]  fin;
    logic        ordy;
    logic        clr;
    logic        e_ov;
    logic        e_ir;
    logic [15:0] e_data;
    logic [3:0]  e_flags;
    logic [3:0]  e_ff;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic iv, input logic [15:0] din, input logic [3:0] fin,
                     input logic ordy, input logic clr,
                     input logic e_ov, input logic e_ir, input logic [15:0] e_data,
                     input logic [3:0] e_flags, input logic [3:0] e_ff, input logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.din = din; v.fin = fin; v.ordy = ordy; v.clr = clr;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_data = e_data; v.e_flags = e_flags;
    v.e_ff = e_ff; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic e_ov, input logic e_ir,
                       input logic [15:0] e_data, input logic [3:0] e_flags,
                       input logic [3:0] e_ff, input logic [2:0] e_cnt);
    n_vec++;
    if ({out_valid, in_ready, out_data, out_flags, fflags, count} !==
        {e_ov, e_ir, e_data, e_flags, e_ff, e_cnt}) begin
      n_err++;
      $display("FAIL %s: got ov=%b ir=%b data=%h flags=%b ff=%b cnt=%0d, want ov=%b ir=%b data=%h flags=%b ff=%b cnt=%0d",
               name, out_valid, in_ready, out_data, out_flags, fflags, count,
               e_ov, e_ir, e_data, e_flags, e_ff, e_cnt);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] din, input logic [3:0] fin,
                       input logic ordy, input logic clr);
    in_valid     = iv;
    in_result    = din;
    {in_invalid, in_overflow, in_underflow, in_inexact} = fin;
    out_ready    = ordy;
    fflags_clear = clr;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0);

    // single push / pop
    add(1, 16'h40E0, 4'b0000, 0, 0,  1, 1, 16'h40E0, 4'b0000, 4'b0000, 3'd1);
    add(0, 16'h0000, 4'b0000, 1, 0,  0, 1, 16'h0000, 4'b0000, 4'b0000, 3'd0);
    // fill, overflow attempt, drain
    add(1, 16'h3F80, 4'b0000, 0, 0,  1, 1, 16'h3F80, 4'b0000, 4'b0000, 3'd1);
    add(1, 16'h4000, 4'b0000, 0, 0,  1, 1, 16'h3F80, 4'b0000, 4'b0000, 3'd2);
    add(1, 16'h4040, 4'b0000, 0, 0,  1, 1, 16'h3F80, 4'b0000, 4'b0000, 3'd3);
    add(1, 16'h4080, 4'b0000, 0, 0,  1, 0, 16'h3F80, 4'b0000, 4'b0000, 3'd4);
    add(1, 16'h40A0, 4'b0000, 0, 0,  1, 0, 16'h3F80, 4'b0000, 4'b0000, 3'd4);
    add(0, 16'h0000, 4'b0000, 1, 0,  1, 1, 16'h4000, 4'b0000, 4'b0000, 3'd3);
    add(0, 16'h0000, 4'b0000, 1, 0,  1, 1, 16'h4040, 4'b0000, 4'b0000, 3'd2);
    add(0, 16'h0000, 4'b0000, 1, 0,  1, 1, 16'h4080, 4'b0000, 4'b0000, 3'd1);
    add(0, 16'h0000, 4'b0000, 1, 0,  0, 1, 16'h0000, 4'b0000, 4'b0000, 3'd0);
    // streaming push+pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      add(1, 16'(32'h4100 + i), 4'b0000, 1, 0,  1, 1, 16'(32'h4100 + i), 4'b0000, 4'b0000, 3'd1);
    end
    add(0, 16'h0000, 4'b0000, 1, 0,  0, 1, 16'h0000, 4'b0000, 4'b0000, 3'd0);
    // sticky flags
    add(1, 16'h7F80, 4'b0101, 0, 0,  1, 1, 16'h7F80, 4'b0101, 4'b0101, 3'd1);
    add(1, 16'h0000, 4'b0011, 0, 0,  1, 1, 16'h7F80, 4'b0101, 4'b0111, 3'd2);
    add(0, 16'h0000, 4'b0000, 1, 0,  1, 1, 16'h0000, 4'b0011, 4'b0111, 3'd1);
    add(1, 16'h7FC0, 4'b1000, 1, 1,  1, 1, 16'h7FC0, 4'b1000, 4'b1000, 3'd1);
    add(0, 16'h0000, 4'b0000, 1, 0,  0, 1, 16'h0000, 4'b0000, 4'b1000, 3'd0);
    // pops while empty
    for (int i = 0; i < 3; i++) begin
      add(0, 16'h0000, 4'b0000, 1, 0,  0, 1, 16'h0000, 4'b0000, 4'b1000, 3'd0);
    end
    add(0, 16'h0000, 4'b0000, 0, 1,  0, 1, 16'h0000, 4'b0000, 4'b0000, 3'd0);
    // full: pop with in_valid high must not push
    add(1, 16'h1111, 4'b0000, 0, 0,  1, 1, 16'h1111, 4'b0000, 4'b0000, 3'd1);
    add(1, 16'h2222, 4'b0000, 0, 0,  1, 1, 16'h1111, 4'b0000, 4'b0000, 3'd2);
    add(1, 16'h3333, 4'b0000, 0, 0,  1, 1, 16'h1111, 4'b0000, 4'b0000, 3'd3);
    add(1, 16'h4444, 4'b0000, 0, 0,  1, 0, 16'h1111, 4'b0000, 4'b0000, 3'd4);
    add(1, 16'h5555, 4'b0001, 1, 0,  1, 1, 16'h2222, 4'b0000, 4'b0000, 3'd3);
    add(0, 16'h0000, 4'b0000, 0, 0,  1, 1, 16'h2222, 4'b0000, 4'b0000, 3'd3);
    add(0, 16'h0000, 4'b0000, 1, 0,  1, 1, 16'h3333, 4'b0000, 4'b0000, 3'd2);
    add(0, 16'h0000, 4'b0000, 1, 0,  1, 1, 16'h4444, 4'b0000, 4'b0000, 3'd1);
    add(0, 16'h0000, 4'b0000, 1, 0,  0, 1, 16'h0000, 4'b0000, 4'b0000, 3'd0);

    #12;
    check("reset_state", 1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[k]) begin
      drive(vq[k].iv, vq[k].din, vq[k].fin, vq[k].ordy, vq[k].clr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), vq[k].e_ov, vq[k].e_ir, vq[k].e_data,
            vq[k].e_flags, vq[k].e_ff, vq[k].e_cnt);
    end

    // async reset mid-stream with three entries buffered
    drive(1'b1, 16'hAAAA, 4'b0100, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'hBBBB, 4'b0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'hCCCC, 4'b0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0);
    check("pre_reset", 1'b1, 1'b1, 16'hAAAA, 4'b0100, 4'b0101, 3'd3);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 16'h4321, 4'b0010, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0);
    check("post_reset_push", 1'b1, 1'b1, 16'h4321, 4'b0010, 4'b0010, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
